game_timer_bcd: RTL and testbench
=================================

Name: game_timer_bcd

Overview:
- 4-digit BCD countdown timer in MM:SS format. It is the digit source feeding the board's 4-digit seven-segment scan driver.
- Drives the four digit values directly (dig3 = minutes tens ... dig0 = seconds ones).
- Drives the driver's blank-gating pair: `expired` goes to the driver's `game` input and `blink` goes to its `clk1` input, so the display flashes when time runs out.
- Sits between the game control FSM (start/pause/load pulses) and the display.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per 1 s timer tick. Minimum 2.
- BLINK_DIV, 25_000_000: clk cycles per half-period of `blink`. Minimum 1.
- INIT_VAL, 16'h0200: reset value of {dig3,dig2,dig1,dig0}, BCD (02:00).

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse: begin or resume counting
- pause  in  1  one-cycle pulse: freeze counting
- load  in  1  one-cycle pulse: load load_val
- load_val  in  16  BCD {min_tens, min_ones, sec_tens, sec_ones}
- dig0  out  4  seconds ones
- dig1  out  4  seconds tens
- dig2  out  4  minutes ones
- dig3  out  4  minutes tens
- running  out  1  high in RUN
- expired  out  1  high in EXPIRED (drives display `game`)
- blink  out  1  flash square wave (drives display `clk1`)

Behaviour:
- All outputs are registered, and every register is reset synchronously by rst.
- Reset values:
  - digits = INIT_VAL
  - state = IDLE
  - running = 0, expired = 0, blink = 0
  - prescaler = 0, blink counter = 0
- States: IDLE, RUN, PAUSE, EXPIRED.
- Command priority when pulses coincide: load > pause > start.
- IDLE:
  - load: digits <= clamp(load_val), stay IDLE.
  - start with digits != 0000: go to RUN, prescaler <= 0.
  - start with digits == 0000: go to EXPIRED.
- RUN:
  - load is ignored.
  - pause: go to PAUSE; the prescaler holds its value.
  - The prescaler counts 0..TICK_DIV-1. Its wrap cycle is the tick.
- Tick decrement:
  - Digits update on the clock edge ending the tick cycle, so latency is 1 cycle.
  - Chain: sec_ones decrements; borrow 0->9 into sec_tens; sec_tens wraps 0->5 with borrow into min_ones; min_ones wraps 0->9 into min_tens; min_tens decrements.
  - If the result is 0000, state <= EXPIRED on the same edge as the digit update.
  - A pause pulse in the tick cycle wins: no decrement occurs.
- PAUSE:
  - start: return to RUN, keeping the prescaler value (resume mid-second).
  - load: digits <= clamp(load_val), go to IDLE, prescaler <= 0.
  - pause: ignored.
- EXPIRED:
  - Digits hold at 0000.
  - The blink counter counts 0..BLINK_DIV-1, and `blink` toggles on each wrap.
  - On entry, blink = 0 and the counter = 0.
  - start and pause are ignored.
  - load: digits <= clamp(load_val), go to IDLE, blink <= 0.
- clamp:
  - Any digit > 9 becomes 9.
  - sec_tens > 5 becomes 5.
  - Example: 16'hAB7C loads as 16'h9959.
- Outside EXPIRED, `blink` = 0, so the display shows steadily.
- rst asserted mid-count: the next edge restores reset values regardless of any pulses.
- Maximum value is 99:59. Digits never leave the BCD range.

Optional Feature:
- Macro: GAME_TIMER_WARN_BLINK_EN.
- Defined:
  - While in RUN with digits <= 0010, the blink counter runs and `blink` toggles as in EXPIRED.
  - `expired` is ORed with this warning condition so the display flashes in the last 10 s.
  - The warning is cleared on pause, and its blink state is reset on leaving RUN.
- Undefined: `blink` and `expired` are active only in EXPIRED.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSE, EXPIRED}
  - typedef logic [3:0] bcd_t
  - constants BCD_MAX = 4'd9 and SEC_TENS_MAX = 4'd5.
- Sub-module bcd_digit_dn: one BCD down-counter digit.
  - Parameter MAX.
  - Inputs: dec, load, load_val.
  - Outputs: q and borrow_out (asserted when dec and q == 0).
  - Instantiated four times in a borrow chain.

Test Plan (TICK_DIV=4, BLINK_DIV=3):
- rst 2 cycles, load_val=16'h0102, load, start: digits read 0101 after 4 cycles, then 0100, 0059, 0058. running=1 throughout.
- Count from 0001 in RUN: after 1 tick, digits 0000 and expired=1 on the same edge, running=0. blink reads 0,0,0,1,1,1,0... on successive cycles.
- pause at prescaler=2, wait 20 cycles, start: the next decrement comes exactly 2 cycles after start, with digits unchanged during PAUSE.
- load and start in the same cycle in IDLE with load_val=16'h0030: digits 0030, state stays IDLE. A later start gives RUN.
- load_val=16'hAB7C in IDLE: digits 9959. load during RUN: ignored, count continues.
- rst asserted mid-RUN at digits 0042: the next cycle gives digits 0200, IDLE, blink=0. With GAME_TIMER_WARN_BLINK_EN, loading 0012 and starting gives blink activity beginning at digits 0010.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and digit limits for the MM:SS countdown timer.
package game_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit wrapping 0 -> MAX, with clamped load and borrow out.
module bcd_digit_dn
  import game_pkg::*;
#(
  parameter bcd_t MAX  = BCD_MAX,
  parameter bcd_t INIT = 4'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t q,
  output logic borrow_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (load) begin
      q <= (load_val > MAX) ? MAX : load_val;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

  assign borrow_out = dec && (q == 4'd0);

endmodule

// File: rtl/game_timer_bcd.sv
// MM:SS BCD countdown feeding the seven-segment driver; digits move 1 cycle after the tick.
// GAME_TIMER_WARN_BLINK_EN also flashes the display during the last 10 s of RUN.
module game_timer_bcd
  import game_pkg::*;
#(
  parameter int          TICK_DIV  = 100_000_000,
  parameter int          BLINK_DIV = 25_000_000,
  parameter logic [15:0] INIT_VAL  = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  dig0,
  output logic [3:0]  dig1,
  output logic [3:0]  dig2,
  output logic [3:0]  dig3,
  output logic        running,
  output logic        expired,
  output logic        blink
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  timer_state_t   state, state_n;
  logic [PW-1:0]  presc;
  logic [BW-1:0]  bcnt;
  logic [15:0]    digits;
  logic [3:0]     borrow;
  logic           tick, load_en, presc_wrap, bcnt_wrap, blink_cnt_en, warn_n;

  assign digits     = {dig3, dig2, dig1, dig0};
  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign bcnt_wrap  = (bcnt == BW'(BLINK_DIV - 1));
  assign tick       = (state == RUN) && !pause && presc_wrap;

  always_comb begin
    state_n = state;
    load_en = 1'b0;
    case (state)
      IDLE: begin
        if (load) load_en = 1'b1;
        else if (start && !pause) state_n = (digits == 16'h0000) ? EXPIRED : RUN;
      end
      RUN: begin
        if (pause) state_n = PAUSE;
        // a borrow out of the top digit means the count is corrupt; park it
        else if (tick && (digits == 16'h0001 || borrow[3])) state_n = EXPIRED;
      end
      PAUSE: begin
        if (load) begin
          load_en = 1'b1;
          state_n = IDLE;
        end else if (start && !pause) begin
          state_n = RUN;
        end
      end
      EXPIRED: begin
        if (load) begin
          load_en = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef GAME_TIMER_WARN_BLINK_EN
  // warning uses the post-decrement value so `expired` rises on the edge reaching 00:10
  assign warn_n       = (state_n == RUN) && (tick ? (digits <= 16'h0011) : (digits <= 16'h0010));
  assign blink_cnt_en = ((state == EXPIRED) && (state_n == EXPIRED)) ||
                        ((state == RUN) && (state_n == RUN) && (digits <= 16'h0010));
`else
  assign warn_n       = 1'b0;
  assign blink_cnt_en = (state == EXPIRED) && (state_n == EXPIRED);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      expired <= (state_n == EXPIRED) || warn_n;
    end
  end

  // prescaler survives PAUSE so a resume finishes the interrupted second
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else begin
      case (state)
        RUN:     if (!pause) presc <= presc_wrap ? '0 : presc + PW'(1);
        PAUSE:   if (load) presc <= '0;
        default: presc <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_cnt_en) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (bcnt_wrap) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  bcd_digit_dn #(.MAX(BCD_MAX), .INIT(INIT_VAL[3:0])) u_sec_ones (
    .clk(clk), .rst(rst), .dec(tick), .load(load_en), .load_val(load_val[3:0]),
    .q(dig0), .borrow_out(borrow[0])
  );

  bcd_digit_dn #(.MAX(SEC_TENS_MAX), .INIT(INIT_VAL[7:4])) u_sec_tens (
    .clk(clk), .rst(rst), .dec(borrow[0]), .load(load_en), .load_val(load_val[7:4]),
    .q(dig1), .borrow_out(borrow[1])
  );

  bcd_digit_dn #(.MAX(BCD_MAX), .INIT(INIT_VAL[11:8])) u_min_ones (
    .clk(clk), .rst(rst), .dec(borrow[1]), .load(load_en), .load_val(load_val[11:8]),
    .q(dig2), .borrow_out(borrow[2])
  );

  bcd_digit_dn #(.MAX(BCD_MAX), .INIT(INIT_VAL[15:12])) u_min_tens (
    .clk(clk), .rst(rst), .dec(borrow[2]), .load(load_en), .load_val(load_val[15:12]),
    .q(dig3), .borrow_out(borrow[3])
  );

endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd: directed vector table plus randomized run against a seconds-based model.
module tb_game_timer_bcd;

  localparam int TD = 4;
  localparam int BD = 3;

  logic        clk = 1'b0;
  logic        rst, start, pause, load;
  logic [15:0] load_val;
  logic [3:0]  dig0, dig1, dig2, dig3;
  logic        running, expired, blink;

  always #5 clk = ~clk;

  game_timer_bcd #(.TICK_DIV(TD), .BLINK_DIV(BD), .INIT_VAL(16'h0200)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load), .load_val(load_val),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .running(running), .expired(expired), .blink(blink)
  );

  typedef struct {
    logic        r, s, p, l;
    logic [15:0] lv;
    logic [15:0] dig;
    logic        run, ex, bk;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  // model: 0 idle, 1 run, 2 pause, 3 expired; time kept as whole seconds
  int m_state, m_secs, m_presc, m_bcnt;
  bit m_blink, m_exp_o;

  function automatic void add(input logic r, s, p, l, input logic [15:0] lv, dig,
                              input logic run, ex, bk);
    vecs.push_back('{r, s, p, l, lv, dig, run, ex, bk});
  endfunction

  function automatic int lim(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic int clamp_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = lim(int'(v[15:12]), 9);
    mo = lim(int'(v[11:8]), 9);
    st = lim(int'(v[7:4]), 5);
    so = lim(int'(v[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic void model_step(input logic r, s, p, l, input logic [15:0] lv);
    int ost, os;
    bit cnt_en;
    if (r) begin
      m_state = 0; m_secs = 120; m_presc = 0; m_bcnt = 0; m_blink = 0; m_exp_o = 0;
      return;
    end
    ost = m_state;
    os  = m_secs;
    case (m_state)
      0: if (l) m_secs = clamp_secs(lv);
         else if (s && !p) begin
           m_state = (m_secs == 0) ? 3 : 1;
           m_presc = 0;
         end
      1: if (p) m_state = 2;
         else if (m_presc == TD - 1) begin
           m_presc = 0;
           m_secs  = m_secs - 1;
           if (m_secs == 0) m_state = 3;
         end else m_presc = m_presc + 1;
      2: if (l) begin
           m_secs = clamp_secs(lv); m_state = 0; m_presc = 0;
         end else if (s && !p) m_state = 1;
      default: if (l) begin
           m_secs = clamp_secs(lv); m_state = 0;
         end
    endcase
    cnt_en = (ost == 3) && (m_state == 3);
`ifdef GAME_TIMER_WARN_BLINK_EN
    if (ost == 1 && m_state == 1 && os <= 10) cnt_en = 1;
`endif
    if (cnt_en) begin
      if (m_bcnt == BD - 1) begin
        m_bcnt = 0; m_blink = !m_blink;
      end else m_bcnt = m_bcnt + 1;
    end else begin
      m_bcnt = 0; m_blink = 0;
    end
    m_exp_o = (m_state == 3);
`ifdef GAME_TIMER_WARN_BLINK_EN
    if (m_state == 1 && m_secs <= 10) m_exp_o = 1;
`endif
  endfunction

  task automatic cyc(input logic r, s, p, l, input logic [15:0] lv);
    @(negedge clk);
    rst = r; start = s; pause = p; load = l; load_val = lv;
    model_step(r, s, p, l, lv);
    @(posedge clk);
    #1;
  endtask

  function automatic void check(input string nm, input logic [15:0] ed, input logic er, ee, eb);
    checks++;
    if ({dig3, dig2, dig1, dig0} !== ed || running !== er || expired !== ee || blink !== eb) begin
      failures++;
      $display("FAIL %s got dig=%h run=%b exp=%b blk=%b want dig=%h run=%b exp=%b blk=%b",
               nm, {dig3, dig2, dig1, dig0}, running, expired, blink, ed, er, ee, eb);
    end
  endfunction

  initial begin
    logic ee, eb;
    logic [15:0] lv;
    rst = 1'b1; start = 1'b0; pause = 1'b0; load = 1'b0; load_val = '0;

    add(1,0,0,0,16'h0000, 16'h0200,0,0,0);
    add(1,0,0,0,16'h0000, 16'h0200,0,0,0);
    add(0,0,0,1,16'h0102, 16'h0102,0,0,0);
    add(0,1,0,0,16'h0000, 16'h0102,1,0,0);
    repeat (3) add(0,0,0,0,16'h0000, 16'h0102,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0101,1,0,0);
    repeat (3) add(0,0,0,0,16'h0000, 16'h0101,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0100,1,0,0);
    repeat (3) add(0,0,0,0,16'h0000, 16'h0100,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0059,1,0,0);
    repeat (3) add(0,0,0,0,16'h0000, 16'h0059,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0058,1,0,0);
    add(0,0,1,0,16'h0000, 16'h0058,0,0,0);
    add(0,0,0,1,16'h0001, 16'h0001,0,0,0);
    add(0,1,0,0,16'h0000, 16'h0001,1,0,0);
    repeat (3) add(0,0,0,0,16'h0000, 16'h0001,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,0);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,0);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,0);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,1);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,1);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,1);
    add(0,0,0,0,16'h0000, 16'h0000,0,1,0);
    add(0,1,1,0,16'h0000, 16'h0000,0,1,0);
    add(0,0,0,1,16'h0030, 16'h0030,0,0,0);
    add(0,1,0,1,16'h0030, 16'h0030,0,0,0);
    add(0,1,0,0,16'h0000, 16'h0030,1,0,0);
    add(0,0,0,1,16'hAB7C, 16'h0030,1,0,0);
    repeat (2) add(0,0,0,0,16'h0000, 16'h0030,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0029,1,0,0);
    add(0,0,1,0,16'h0000, 16'h0029,0,0,0);
    add(0,0,0,1,16'hAB7C, 16'h9959,0,0,0);
    add(0,1,0,0,16'h0000, 16'h9959,1,0,0);
    repeat (2) add(0,0,0,0,16'h0000, 16'h9959,1,0,0);
    add(0,0,1,0,16'h0000, 16'h9959,0,0,0);
    repeat (20) add(0,0,0,0,16'h0000, 16'h9959,0,0,0);
    add(0,1,0,0,16'h0000, 16'h9959,1,0,0);
    add(0,0,0,0,16'h0000, 16'h9959,1,0,0);
    add(0,0,0,0,16'h0000, 16'h9958,1,0,0);
    add(0,0,1,0,16'h0000, 16'h9958,0,0,0);
    add(0,0,0,1,16'h0042, 16'h0042,0,0,0);
    add(0,1,0,0,16'h0000, 16'h0042,1,0,0);
    add(0,0,0,0,16'h0000, 16'h0042,1,0,0);
    add(1,1,0,1,16'h1234, 16'h0200,0,0,0);
    add(0,0,0,1,16'h0000, 16'h0000,0,0,0);
    add(0,1,0,0,16'h0000, 16'h0000,0,1,0);
    add(0,0,0,1,16'h0200, 16'h0200,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].l, vecs[i].lv);
      ee = vecs[i].ex;
      eb = vecs[i].bk;
`ifdef GAME_TIMER_WARN_BLINK_EN
      ee = m_exp_o;
      eb = m_blink;
`endif
      check($sformatf("vec%0d", i), vecs[i].dig, vecs[i].run, ee, eb);
    end

`ifdef GAME_TIMER_WARN_BLINK_EN
    cyc(0,0,0,1,16'h0012);
    cyc(0,1,0,0,16'h0000);
    for (int i = 0; i < 12 * TD; i++) begin
      cyc(0,0,0,0,16'h0000);
      check("warn", to_bcd(m_secs), m_state == 1, m_exp_o, m_blink);
    end
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
      else lv = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom)};
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0, lv);
      check($sformatf("rand%0d", i), to_bcd(m_secs), m_state == 1, m_exp_o, m_blink);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
